// File: rtl/longalu_if.sv
// Pipeline-side bundle for the long-ALU: start/abort, MTHI/MTLO writes and the HI/LO view.
// phi2 travels with the bundle because it qualifies every pipeline-driven strobe.
interface longalu_if;
    logic        phi2;
    logic        go;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        abort;
    logic        wrhi;
    logic        wrlo;
    logic [63:0] wdata;
    logic        busy;
    logic [63:0] hi;
    logic [63:0] lo;

    modport master (
        output phi2, go, op, a, b, abort, wrhi, wrlo, wdata,
        input  busy, hi, lo
    );

    modport slave (
        input  phi2, go, op, a, b, abort, wrhi, wrlo, wdata,
        output busy, hi, lo
    );
endinterface

// File: rtl/longalu.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; sign-magnitude datapath with one
// fix-up cycle that applies signs and commits, or aborts cleanly without touching HI/LO.
module longalu (
    input logic       clk,
    input logic       resetn,
    longalu_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e       state_q, state_d;
    logic [2:0]   op_q;
    logic         neg_q;
    logic         rsgn_q;
    logic         dz_q;
    logic [5:0]   cnt_q;
    logic [127:0] acc_q;
    logic [63:0]  opr_q;
    logic [63:0]  mpl_q;
    logic [63:0]  dvd_q;
    logic [63:0]  hi_q, lo_q;

    logic         start, kill, commit;
    logic         uns, wide;
    logic [63:0]  a_ext, b_ext, a_mag, b_mag, a_just, b_just;
    logic         a_neg, b_neg;

    assign uns    = bus.op[0];
    assign wide   = bus.op[2];
    assign a_ext  = wide ? bus.a : (uns ? {32'b0, bus.a[31:0]} : {{32{bus.a[31]}}, bus.a[31:0]});
    assign b_ext  = wide ? bus.b : (uns ? {32'b0, bus.b[31:0]} : {{32{bus.b[31]}}, bus.b[31:0]});
    assign a_neg  = !uns && a_ext[63];
    assign b_neg  = !uns && b_ext[63];
    assign a_mag  = a_neg ? -a_ext : a_ext;
    assign b_mag  = b_neg ? -b_ext : b_ext;
    // Left-justify 32-bit operands so each step always consumes bit 63.
    assign a_just = wide ? a_mag : {a_mag[31:0], 32'b0};
    assign b_just = wide ? b_mag : {b_mag[31:0], 32'b0};

    assign start  = (state_q == StIdle) && bus.phi2 && bus.go;
    assign kill   = (state_q != StIdle) && bus.phi2 && bus.abort;
    assign commit = (state_q == StFix) && !kill;

    // One radix-2 step for each operation class.
    logic [127:0] acc_mul, acc_div;
    logic [64:0]  rem_sh;
    logic [63:0]  rem_sub;
    logic         ge;

    assign acc_mul = {acc_q[126:0], 1'b0} + (mpl_q[63] ? {64'b0, opr_q} : 128'b0);
    assign rem_sh  = {acc_q[127:64], acc_q[63]};
    assign ge      = rem_sh >= {1'b0, opr_q};
    assign rem_sub = rem_sh[63:0] - opr_q;
    assign acc_div = {(ge ? rem_sub : rem_sh[63:0]), acc_q[62:0], ge};

    // Sign fix-up and result selection for the commit.
    logic [127:0] prod;
    logic [63:0]  quo, rem, res_lo, res_hi, fin_lo, fin_hi;

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -acc_q[63:0] : acc_q[63:0];
        rem    = rsgn_q ? -acc_q[127:64] : acc_q[127:64];
        res_lo = 64'b0;
        res_hi = 64'b0;
        if (dz_q) begin
            res_lo = '1;
            res_hi = dvd_q;
        end else if (op_q[1]) begin
            res_lo = quo;
            res_hi = rem;
        end else begin
            res_lo = prod[63:0];
            res_hi = op_q[2] ? prod[127:64] : {32'b0, prod[63:32]};
        end
        fin_lo = op_q[2] ? res_lo : {{32{res_lo[31]}}, res_lo[31:0]};
        fin_hi = op_q[2] ? res_hi : {{32{res_hi[31]}}, res_hi[31:0]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun: begin
                if (kill) state_d = StIdle;
                else if (cnt_q == 6'd0) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            op_q    <= 3'b0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= 6'd0;
            acc_q   <= 128'b0;
            opr_q   <= 64'b0;
            mpl_q   <= 64'b0;
            dvd_q   <= 64'b0;
            hi_q    <= 64'b0;
            lo_q    <= 64'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= bus.op;
                neg_q  <= a_neg ^ b_neg;
                rsgn_q <= a_neg;
                dz_q   <= bus.op[1] && (b_mag == 64'b0);
                cnt_q  <= wide ? 6'd63 : 6'd31;
                dvd_q  <= bus.a;
                mpl_q  <= b_just;
                if (bus.op[1]) begin
                    acc_q <= {64'b0, a_just};
                    opr_q <= b_mag;
                end else begin
                    acc_q <= 128'b0;
                    opr_q <= a_mag;
                end
            end else if (state_q == StRun) begin
                acc_q <= op_q[1] ? acc_div : acc_mul;
                mpl_q <= {mpl_q[62:0], 1'b0};
                cnt_q <= cnt_q - 6'd1;
            end
            if (commit) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end else if (state_q == StIdle && bus.phi2) begin
                // A write coinciding with go lands now; the later commit overwrites it.
                if (bus.wrhi) hi_q <= bus.wdata;
                if (bus.wrlo) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_longalu.sv
// Scoreboard bench for longalu: expected HI/LO/busy-length queued at issue,
// popped and compared by a monitor each time busy falls.
module tb_longalu;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    longalu_if bus ();

    longalu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] hi;
        logic [63:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles and compare on every busy fall.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (prev_busy && !bus.busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no completion",
                             bus.hi, bus.lo);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                    check({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                    check({mon_e.name, "_cycles"}, 64'(busy_cnt), 64'(mon_e.cycles));
                end
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.go = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 200 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] ehi, input logic [63:0] elo,
                          input int cyc);
        sb.push_back('{name, ehi, elo, cyc});
        start(op, a, b);
        wait_idle(name);
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [63:0] d);
        @(negedge clk);
        bus.wrhi  = hi_en;
        bus.wrlo  = lo_en;
        bus.wdata = d;
        @(negedge clk);
        bus.wrhi  = 1'b0;
        bus.wrlo  = 1'b0;
    endtask

    initial begin
        bus.phi2 = 1'b1; bus.go = 1'b0; bus.op = 3'b0; bus.a = 64'b0; bus.b = 64'b0;
        bus.abort = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0; bus.wdata = 64'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_hi", bus.hi, 64'd0);
        check("rst_lo", bus.lo, 64'd0);

        mt(1'b1, 1'b1, 64'h0000_0000_0000_AAAA);
        check("mt_hi", bus.hi, 64'hAAAA);
        check("mt_lo", bus.lo, 64'hAAAA);

        // go without phi2 must not start.
        @(negedge clk);
        bus.phi2 = 1'b0; bus.go = 1'b1; bus.op = 3'b000; bus.a = 64'd2; bus.b = 64'd3;
        @(negedge clk);
        bus.phi2 = 1'b1; bus.go = 1'b0;
        check("nophi2_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of DMULT: immediate clear, no commit afterwards.
        start(3'b100, 64'd5, 64'd3);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", bus.hi, 64'd0);
        check("midrst_lo", bus.lo, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (80) @(negedge clk);
        check("postrst_busy", 64'(bus.busy), 64'd0);
        check("postrst_hi", bus.hi, 64'd0);
        check("postrst_lo", bus.lo, 64'd0);

        run_op("mult_m3x7", 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 33);
        run_op("divu_100_7", 3'b011, 64'd100, 64'd7, 64'd2, 64'd14, 33);
        run_op("div_m7_2", 3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33);

        // DMULTU with a stray go and MTHI while busy; both must be ignored.
        sb.push_back('{"dmultu_ones", 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65});
        start(3'b101, '1, '1);
        repeat (5) @(negedge clk);
        bus.go = 1'b1; bus.op = 3'b011; bus.a = 64'd1; bus.b = 64'd1;
        bus.wrhi = 1'b1; bus.wdata = 64'hDEAD;
        @(negedge clk);
        bus.go = 1'b0; bus.wrhi = 1'b0;
        check("busy_wrhi_hi", bus.hi, 64'hFFFF_FFFF_FFFF_FFFF);
        check("busy_go_busy", 64'(bus.busy), 64'd1);
        wait_idle("dmultu_ones");

        run_op("divu_5_0", 3'b011, 64'd5, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("div_ovf", 3'b010, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, 64'hFFFF_FFFF_8000_0000, 33);
        run_op("ddiv_m100_7", 3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("dmult_m2x3", 3'b100, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run_op("multu_big", 3'b001, 64'h0000_0000_FFFF_FFFF, 64'd2,
               64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        // go and MTLO together: write lands now, commit overwrites later.
        sb.push_back('{"go_wrlo", 64'd0, 64'd12, 33});
        @(negedge clk);
        bus.go = 1'b1; bus.op = 3'b001; bus.a = 64'd3; bus.b = 64'd4;
        bus.wrlo = 1'b1; bus.wdata = 64'h99;
        @(negedge clk);
        bus.go = 1'b0; bus.wrlo = 1'b0;
        check("go_wrlo_early_lo", bus.lo, 64'h99);
        wait_idle("go_wrlo");

        // MTLO then DDIV aborted after 10 run cycles: no commit.
        mt(1'b0, 1'b1, 64'h1234);
        check("mtlo_lo", bus.lo, 64'h1234);
        sb.push_back('{"ddiv_abort", 64'd0, 64'h1234, 11});
        start(3'b110, 64'd1000, 64'd3);
        repeat (10) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        wait_idle("ddiv_abort");
        repeat (70) @(negedge clk);
        check("abort_lo_late", bus.lo, 64'h1234);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/longalu.md
Name: longalu

Overview:
- Iterative multiply/divide unit for the integer pipeline, downstream of the EX stage; executes MULT/MULTU/DIV/DIVU/DMULT/DMULTU/DDIV/DDIVU.
- The pipeline raises `go` for a long-ALU instruction, with operands taken from the EX r0/r1 operand registers, and stalls while `busy` is high.
- Owns the architectural HI/LO registers.
- Also accepts MTHI/MTLO writes; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- none (operand width fixed at 64; iteration count derived from `op`)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- phi2  in  1  pipeline phase-2 enable; `go`, `wrhi`, `wrlo` and `abort` are sampled only on clk edges with `phi2` high
- go  in  1  start operation
- op  in  3  [0]=unsigned, [1]=divide (else multiply), [2]=64-bit (else 32-bit)
- a  in  64  rs operand (multiplicand / dividend)
- b  in  64  rt operand (multiplier / divisor)
- abort  in  1  pipeline kill; cancels operation in flight
- wrhi  in  1  MTHI write
- wrlo  in  1  MTLO write
- wdata  in  64  MTHI/MTLO data
- busy  out  1  operation in progress
- hi  out  64  HI register
- lo  out  64  LO register

Behaviour:
- Reset (async, resetn=0): state IDLE, busy=0, hi=0, lo=0, counters and accumulators cleared. Release is synchronous to clk.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, go&phi2:
  - Latch op.
  - 32-bit ops use a[31:0]/b[31:0], sign-interpreted per op[0].
  - Signed ops: record the operand signs, then load operand magnitudes.
  - Count = N-1, with N=32 (32-bit) or N=64 (64-bit).
  - Next state RUN; busy=1 from the next cycle.
- RUN: one radix-2 step per clk, independent of phi2.
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring; shift remainder, trial-subtract divisor, set quotient bit.
  - Count decrements each step; after the step at count=0 go to FIX.
- FIX: one cycle.
  - Apply sign correction:
    - signed multiply: product negated if the operand signs differ;
    - signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Commit:
    - 32-bit: lo=sext(result_lo[31:0]), hi=sext(result_hi[31:0]), where multiply lo/hi are product[31:0]/[63:32] and divide lo/hi are quotient/remainder.
    - 64-bit: lo=product[63:0] or quotient; hi=product[127:64] or remainder.
  - Then IDLE; busy falls on the following edge.
- Latency: busy high for exactly N+1 cycles (33 or 65). hi/lo change only at the FIX commit edge.
- Divide by zero (divisor magnitude 0, checked at start):
  - Iterations still run.
  - Commit lo = all ones (64-bit ones, or sext(0xFFFFFFFF)) and hi = dividend (sext of low 32 for 32-bit ops).
  - Sign fix bypassed; signedness ignored.
- Overflow case: signed DIV 0x80000000 / -1 gives quotient 0x80000000 after wrap, so lo=0xFFFFFFFF80000000, hi=0. No exception is raised.
- abort&phi2 in RUN/FIX: return to IDLE next edge, busy=0, hi/lo untouched (no partial commit). abort in IDLE is ignored.
  - abort has priority over commit in FIX.
  - A simultaneous go with abort is ignored.
- go while busy: ignored. The pipeline guarantees it stalls, but the RTL must not restart.
- wrhi/wrlo&phi2 in IDLE: hi/lo <= wdata. Ignored while busy.
  - If go and wrhi/wrlo coincide in IDLE, the write lands and the operation still starts; its commit later overwrites.
- No outputs depend combinationally on inputs; busy, hi, lo are registered.

Test Plan:
- Reset mid-RUN (resetn low 1 cycle during DMULT) -> busy=0, hi=lo=0 immediately, no later commit.
- MULT a=-3 (0xFFFFFFFFFFFFFFFD), b=7 -> busy 33 cycles, then lo=0xFFFFFFFFFFFFFFEB, hi=0xFFFFFFFFFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFFFFFFFFFD, hi=0xFFFFFFFFFFFFFFFF.
- DMULTU a=b=0xFFFFFFFFFFFFFFFF -> busy 65 cycles, hi=0xFFFFFFFFFFFFFFFE, lo=1.
- DIVU 5/0 -> lo=0xFFFFFFFFFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0xFFFFFFFF80000000, hi=0.
- MTLO 0x1234, then DDIV with abort at cycle 10 -> busy drops next edge, lo stays 0x1234. go while busy is ignored; wrhi while busy leaves hi unchanged.
